ram_arbiter: RTL and testbench

//  Shares the single RAM port between three requesters: core-0 icache fetch, core-1 icache fetch,
//  and the data port driven by coherence_control (two-word block reads/writes, flushes).

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/ram_arbiter_rr.sv | 14 +
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types used by the RAM arbiter and its neighbours.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        GNT_D,
        GNT_I0,
        GNT_I1
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side signals of the RAM arbiter; slave is the arbiter's view.
interface ram_arbiter_if;
    import cpu_types_pkg::*;

    logic [1:0]      iREN;
    word_t [1:0]     iaddr;
    logic [1:0]      iwait;
    word_t [1:0]     iload;
    logic            dREN;
    logic            dWEN;
    logic            dlock;
    word_t           daddr;
    word_t           dstore;
    logic            dwait;
    word_t           dload;
    logic            ramREN;
    logic            ramWEN;
    word_t           ramaddr;
    word_t           ramstore;
    word_t           ramload;
    ramstate_t       ramstate;
    logic            mem_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, dlock, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, dlock, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

endinterface

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin picker: the requester at ptr wins if it asks, otherwise the other one.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = req[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between two icache fetch ports and the coherence data port,
// with data priority, round-robin fetches and a starvation guard for fetches.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic          CLK,
    input  logic          RST,
    ram_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state, next_state;
    logic             rr_ptr, rr_ptr_next;
    logic [CNT_W-1:0] starve_cnt, starve_next, starve_inc;
    logic             rr_gnt, rr_valid;
    logic             d_req, forced, gidx;

    rr_arbiter2 u_rr (
        .req   (bus.iREN),
        .ptr   (rr_ptr),
        .gnt   (rr_gnt),
        .valid (rr_valid)
    );

    assign d_req      = bus.dREN | bus.dWEN;
    assign forced     = (starve_cnt >= LIMIT) && (|bus.iREN);
    assign gidx       = (state == GNT_I1);
    assign starve_inc = (&starve_cnt) ? starve_cnt : starve_cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            rr_ptr     <= rr_ptr_next;
            starve_cnt <= starve_next;
        end
    end

    // RAM port mux kept apart from the ramstate-dependent logic so no comb path runs through the RAM.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            GNT_D: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            GNT_I0, GNT_I1: begin
                bus.ramREN  = bus.iREN[gidx];
                bus.ramaddr = bus.iaddr[gidx];
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state  = state;
        rr_ptr_next = rr_ptr;
        starve_next = starve_cnt;
        bus.iwait   = 2'b11;
        bus.iload   = '0;
        bus.dwait   = 1'b1;
        bus.dload   = '0;
        bus.mem_err = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !forced)
                    next_state = GNT_D;
                else if (rr_valid)
                    next_state = rr_gnt ? GNT_I1 : GNT_I0;
            end
            GNT_D: begin
                bus.dload   = bus.ramload;
                bus.mem_err = (bus.ramstate == ERROR);
                if (!d_req) begin
                    next_state = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.dwait   = 1'b0;
                    starve_next = (|bus.iREN) ? starve_inc : '0;
                    // Burst continuation is judged on the post-completion count.
                    if (bus.dlock && !((starve_next >= LIMIT) && (|bus.iREN)))
                        next_state = GNT_D;
                    else
                        next_state = IDLE;
                end
            end
            GNT_I0, GNT_I1: begin
                bus.iload[gidx] = bus.ramload;
                bus.mem_err     = (bus.ramstate == ERROR);
                if (!bus.iREN[gidx]) begin
                    next_state = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.iwait[gidx] = 1'b0;
                    rr_ptr_next     = ~gidx;
                    starve_next     = '0;
                    next_state      = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a one-BUSY-cycle RAM model and error injection.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    typedef struct {
        int    src;
        word_t data;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    ram_arbiter_if bus ();

    ram_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    word_t       mem [0:1023];
    int unsigned ram_cnt = 0;
    logic        err_inject = 1'b0;
    logic        ram_active;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cmpl_total = 0;
    int   d_cmpl = 0;
    int   i_cmpl [2] = '{0, 0};
    int   cyc = 0;
    int   d_cyc_prev = 0;
    int   d_cyc_last = 0;

    localparam word_t W0 = 32'h1111_0040;
    localparam word_t W1 = 32'h2222_0044;

    function automatic word_t initval(input word_t a);
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_total(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (cmpl_total < target && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        if (cmpl_total < target)
            chk({"timeout_", tag}, cmpl_total, target);
    endtask

    // RAM model: BUSY for one cycle, then ACCESS; ERROR while injected.
    always_comb begin
        ram_active = bus.ramREN | bus.ramWEN;
        if (!ram_active)      bus.ramstate = FREE;
        else if (err_inject)  bus.ramstate = ERROR;
        else if (ram_cnt >= 1) bus.ramstate = ACCESS;
        else                  bus.ramstate = BUSY;
        bus.ramload = (bus.ramstate == ACCESS && bus.ramREN) ? mem[bus.ramaddr[11:2]] : '0;
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!ram_active || bus.ramstate == ACCESS) ram_cnt <= 0;
        else if (bus.ramstate == BUSY)             ram_cnt <= ram_cnt + 1;
        if (bus.ramstate == ACCESS && bus.ramWEN)  mem[bus.ramaddr[11:2]] <= bus.ramstore;
    end

    always @(negedge CLK) begin
        int    nlow;
        int    src;
        word_t data;
        exp_t  e;
        if (!RST) begin
            nlow = $countones({~bus.iwait, ~bus.dwait});
            if (nlow != 0) begin
                chk("one_cmpl", nlow, 1);
                src  = !bus.iwait[0] ? 0 : (!bus.iwait[1] ? 1 : 2);
                data = (src == 2) ? bus.dload : bus.iload[src];
                chk("sb_avail", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("cmpl_src", src, e.src);
                    chk("cmpl_data", data, e.data);
                end
                cmpl_total++;
                if (src == 2) begin
                    d_cmpl++;
                    d_cyc_prev = d_cyc_last;
                    d_cyc_last = cyc;
                end else begin
                    i_cmpl[src]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, nd, d_base, i1_base;
        for (int i = 0; i < 1024; i++) mem[i] = initval(32'(i * 4));

        RST = 1'b1;
        bus.iREN = 2'b11; bus.iaddr[0] = '0; bus.iaddr[1] = '0;
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.dlock = 1'b1;
        bus.daddr = '0; bus.dstore = '0;

        // Reset held three cycles with every request high
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            chk("rst_ramREN", bus.ramREN, 0);
            chk("rst_ramWEN", bus.ramWEN, 0);
            chk("rst_iwait", bus.iwait, 2'b11);
            chk("rst_dwait", bus.dwait, 1);
            chk("rst_mem_err", bus.mem_err, 0);
        end
        RST = 1'b0;
        bus.iREN = 2'b00; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.dlock = 1'b0;
        @(posedge CLK); #1;
        chk("idle_ramaddr", bus.ramaddr, 0);
        chk("idle_iload", bus.iload, 0);
        chk("idle_ramREN", bus.ramREN, 0);

        // Both cores fetching: alternate starting with core 0
        base = cmpl_total;
        sb.push_back('{0, initval(32'h100)});
        sb.push_back('{1, initval(32'h200)});
        sb.push_back('{0, initval(32'h100)});
        sb.push_back('{1, initval(32'h200)});
        bus.iaddr[0] = 32'h100; bus.iaddr[1] = 32'h200; bus.iREN = 2'b11;
        wait_total("rr", base + 4, 100);
        bus.iREN = 2'b00;

        // Locked two-word write burst racing a core-0 fetch of the first word
        base = cmpl_total;
        sb.push_back('{2, 32'h0});
        sb.push_back('{2, 32'h0});
        sb.push_back('{0, W0});
        bus.dWEN = 1'b1; bus.dlock = 1'b1; bus.daddr = 32'h40; bus.dstore = W0;
        bus.iaddr[0] = 32'h40; bus.iREN = 2'b01;
        wait_total("burst_a", base + 1, 20);
        bus.daddr = 32'h44; bus.dstore = W1;
        wait_total("burst_b", base + 2, 20);
        chk("no_bubble", d_cyc_last - d_cyc_prev, 2);
        bus.dWEN = 1'b0; bus.dlock = 1'b0;
        wait_total("burst_f", base + 3, 20);
        bus.iREN = 2'b00;

        // Starvation: eight locked data reads, then the waiting core-1 fetch is forced in
        base = cmpl_total;
        for (int k = 0; k < 8; k++)
            sb.push_back('{2, (k == 0) ? W1 : initval(32'(32'h44 + 4 * k))});
        sb.push_back('{1, initval(32'h600)});
        for (int k = 8; k < 10; k++)
            sb.push_back('{2, initval(32'(32'h44 + 4 * k))});
        d_base = d_cmpl; i1_base = i_cmpl[1]; nd = 0; n = 0;
        bus.dREN = 1'b1; bus.dlock = 1'b1; bus.daddr = 32'h44;
        bus.iaddr[1] = 32'h600; bus.iREN = 2'b10;
        while (cmpl_total < base + 11 && n < 400) begin
            @(posedge CLK); #1;
            n++;
            if (d_cmpl != d_base + nd) begin
                nd = d_cmpl - d_base;
                bus.daddr = 32'(32'h44 + 4 * nd);
                if (nd >= 10) begin
                    bus.dREN = 1'b0; bus.dlock = 1'b0;
                end
            end
            if (i_cmpl[1] != i1_base) bus.iREN = 2'b00;
        end
        if (cmpl_total < base + 11) chk("timeout_starve", cmpl_total, base + 11);
        bus.dREN = 1'b0; bus.dlock = 1'b0; bus.iREN = 2'b00;
        @(posedge CLK); #1;

        // Data read withdrawn while RAM is BUSY
        base = cmpl_total;
        sb.push_back('{0, initval(32'h80)});
        bus.dREN = 1'b1; bus.daddr = 32'h90;
        n = 0;
        while (!bus.ramREN && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("wd_grant", bus.ramREN, 1);
        chk("wd_busy_addr", bus.ramaddr, 32'h90);
        bus.dREN = 1'b0; bus.iaddr[0] = 32'h80; bus.iREN = 2'b01;
        #1;
        chk("wd_ren_drop", bus.ramREN, 0);
        chk("wd_dwait", bus.dwait, 1);
        @(posedge CLK); #1;
        chk("wd_idle_ren", bus.ramREN, 0);
        chk("wd_idle_dwait", bus.dwait, 1);
        @(posedge CLK); #1;
        chk("wd_i0_ren", bus.ramREN, 1);
        chk("wd_i0_addr", bus.ramaddr, 32'h80);
        wait_total("wd", base + 1, 20);
        bus.iREN = 2'b00;

        // RAM ERROR during a core-0 fetch, then normal completion
        base = cmpl_total;
        sb.push_back('{0, initval(32'h70)});
        bus.iaddr[0] = 32'h70; err_inject = 1'b1; bus.iREN = 2'b01;
        @(posedge CLK); #1;
        for (int k = 0; k < 3; k++) begin
            chk("err_pulse", bus.mem_err, 1);
            chk("err_iwait", bus.iwait, 2'b11);
            chk("err_hold", bus.ramREN, 1);
            @(posedge CLK); #1;
        end
        err_inject = 1'b0;
        #1;
        chk("err_clear", bus.mem_err, 0);
        wait_total("err", base + 1, 20);
        bus.iREN = 2'b00;
        @(posedge CLK); #1;

        // Reset in the middle of a data grant aborts it silently
        base = cmpl_total;
        bus.dREN = 1'b1; bus.daddr = 32'h48;
        n = 0;
        while (!bus.ramREN && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("mr_grant", bus.ramREN, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("mr_ramREN", bus.ramREN, 0);
        chk("mr_dwait", bus.dwait, 1);
        bus.dREN = 1'b0; RST = 1'b0;
        @(posedge CLK); #1;
        chk("mr_idle", bus.ramREN, 0);
        chk("mr_no_cmpl", cmpl_total, base);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
